stage_wb: RTL and testbench
===========================

// Module: stage_wb
// PURPOSE
//  Writeback stage of the lc3b pipeline: the register-file writer feeding stage_ID's regfile write port.
//  Latches MEM/WB results, selects writeback data, drives dest/data/load to the regfile and owns the NZP CC register.
//  Also computes branch enable and counts retired instructions.
// PARAMETERS
//  CNT_WIDTH   16      width of retired-instruction counter
//  CC_RESET    3'b010  NZP value after reset (Z set)
// PORTS
//  clk                 in   1   pipeline clock
//  reset               in   1   synchronous, active-high
//  valid_in            in   1   MEM stage presents a real instruction (0 = bubble)
//  ir_in               in   16  instruction word (lc3b_word)
//  control_in          in   ctl lc3b_control_word from control_rom
//  alu_in              in   16  ALU result
//  mem_rdata_in        in   16  data-memory read word
//  mem_addr_in         in   16  data-memory address (bit 0 = byte lane)
//  pc_in               in   16  incremented PC (for JSR/TRAP link)
//  regfile_dest_out    out  3   regfile write register (lc3b_reg)
//  regfile_data_out    out  16  regfile write data
//  regfile_load_out    out  1   regfile write enable
//  cc_out              out  3   current NZP register
//  branch_enable_out   out  1   |(ir_in[11:9] & cc_out)
//  retired_out         out  CNT_WIDTH  retired-instruction count
//  bypass_valid_out    out  1   WB_BYPASS_EN only; else tied 0
//  bypass_reg_out      out  3   WB_BYPASS_EN only; else tied 0
//  bypass_data_out     out  16  WB_BYPASS_EN only; else tied 0
// BEHAVIOUR
//  - Pipeline reg: every posedge, captures valid_in, ir_in, control_in, alu/mem/addr/pc; no stall input (upstream inserts bubbles).
//  - Latency 1: inputs at edge N -> regfile outputs valid during cycle N+1; regfile commits, cc updates at edge N+1.
//  - wb_sel (lc3b_wb_sel): ALU -> alu; MEM_WORD -> mem_rdata; MEM_BYTE -> zero-extended mem_rdata[15:8] if addr[0] else [7:0];
//    PC -> pc. Unknown encodings select ALU.
//  - dest: control.dest_sel ? 3'd7 : ir[11:9].
//  - regfile_load_out = valid_q & control_q.regfile_load; 0 on bubble.
//  - CC: if valid_q & control_q.load_cc, cc <= nzp(regfile_data_out): N=bit15, Z=all zero, P otherwise; exactly one bit set.
//  - branch_enable_out combinational on ir_in and registered cc (sees cc updated at the prior edge).
//  - Retire: counter +1 each edge with valid_q=1; wraps 2^CNT_WIDTH-1 -> 0; bubbles do not count.
//  - Reset: valid_q=0, control_q=0, cc=CC_RESET, retired=0; all regfile/bypass outputs 0 next cycle.
//    Reset wins over valid_in; in-flight write dropped.
//  - Back-to-back writes to same reg: each commits in order; the last wins.
// CONFIGURATION
//  WB_BYPASS_EN defined: bypass_valid_out=regfile_load_out, bypass_reg_out=dest, bypass_data_out=wb data,
//    combinationally for ID/EX forwarding.
//  Not defined: bypass outputs tied 0, no extra logic; ID reads via regfile only.
// STRUCTURE
//  lc3b_types: lc3b_nzp, lc3b_wb_sel enum, control-word fields regfile_load/load_cc/dest_sel/wb_sel.
//  Sub-module: nzp_gen (16-bit word -> lc3b_nzp), reused by any future CC logic.
// TESTING
//  ADD R1 (alu=16'h8000, load, load_cc) -> next cycle dest=1, data=8000, load=1; after edge cc=100.
//  LDB addr=16'h0011, mem=16'hAB34, wb_sel=MEM_BYTE -> data=16'h00AB; addr=0010 -> 16'h0034.
//  JSR dest_sel=1, pc=16'h3002 -> dest=7, data=16'h3002, cc unchanged (load_cc=0).
//  valid_in=0 with regfile_load=1 -> load_out=0, cc and retired unchanged.
//  Retired preloaded to all ones + one valid retire -> 0; reset mid-write -> load_out=0, cc=010, retired=0.
//  With WB_BYPASS_EN: bypass outputs equal regfile outputs each cycle; without: always 0.

Source files
------------

// File: rtl/stage_wb_pkg.sv
// ---------------------------------------------------------------------------
// stage_wb_pkg
// Purpose : lc3b types shared by the writeback stage and its neighbours.
//           Holds the word/register/NZP typedefs, the writeback select enum
//           and the control-word fields that writeback consumes.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package stage_wb_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  lc3b_nzp;

    // 3-bit field so that spare encodings exist; anything beyond PC falls back to ALU.
    typedef enum logic [2:0] {
        WB_ALU      = 3'd0,
        WB_MEM_WORD = 3'd1,
        WB_MEM_BYTE = 3'd2,
        WB_PC       = 3'd3
    } lc3b_wb_sel;

    typedef struct packed {
        logic       regfile_load;
        logic       load_cc;
        logic       dest_sel;
        lc3b_wb_sel wb_sel;
    } lc3b_control_word;

    localparam lc3b_reg LINK_REG = 3'd7;

endpackage

// File: rtl/stage_wb_nzp_gen.sv
// ---------------------------------------------------------------------------
// stage_wb_nzp_gen
// Purpose : classify a 16-bit word into a one-hot NZP code.
// Ports   :
//   word_i  in  16  value to classify
//   nzp_o   out 3   {N,Z,P}; exactly one bit set
// ---------------------------------------------------------------------------
module stage_wb_nzp_gen
    import stage_wb_pkg::*;
(
    input  lc3b_word word_i,
    output lc3b_nzp  nzp_o
);

    always_comb begin
        if (word_i[15]) begin
            nzp_o = 3'b100;
        end else if (word_i == 16'h0000) begin
            nzp_o = 3'b010;
        end else begin
            nzp_o = 3'b001;
        end
    end

endmodule

// File: rtl/stage_wb.sv
// ---------------------------------------------------------------------------
// stage_wb
// Purpose : lc3b writeback stage. Latches the MEM/WB results, selects the
//           writeback data, drives the regfile write port, owns the NZP
//           condition-code register, computes branch enable and counts
//           retired instructions.
// Config  : WB_BYPASS_EN -- when defined, the bypass_* outputs mirror the
//           regfile write port for ID/EX forwarding; otherwise they are 0.
// Ports   :
//   clk                in   1          pipeline clock
//   reset              in   1          synchronous, active-high
//   valid_in           in   1          MEM stage presents a real instruction
//   ir_in              in   16         instruction word
//   control_in         in   ctl        control word
//   alu_in             in   16         ALU result
//   mem_rdata_in       in   16         data-memory read word
//   mem_addr_in        in   16         data-memory address (bit 0 = byte lane)
//   pc_in              in   16         incremented PC (link value)
//   regfile_dest_out   out  3          regfile write register
//   regfile_data_out   out  16         regfile write data
//   regfile_load_out   out  1          regfile write enable
//   cc_out             out  3          current NZP register
//   branch_enable_out  out  1          |(ir_in[11:9] & cc_out)
//   retired_out        out  CNT_WIDTH  retired-instruction count
//   bypass_valid_out   out  1          forwarding valid (WB_BYPASS_EN)
//   bypass_reg_out     out  3          forwarding register (WB_BYPASS_EN)
//   bypass_data_out    out  16         forwarding data (WB_BYPASS_EN)
// ---------------------------------------------------------------------------
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int          CNT_WIDTH = 16,
    parameter logic [2:0]  CC_RESET  = 3'b010
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  lc3b_word             ir_in,
    input  lc3b_control_word     control_in,
    input  lc3b_word             alu_in,
    input  lc3b_word             mem_rdata_in,
    input  lc3b_word             mem_addr_in,
    input  lc3b_word             pc_in,
    output lc3b_reg              regfile_dest_out,
    output lc3b_word             regfile_data_out,
    output logic                 regfile_load_out,
    output lc3b_nzp              cc_out,
    output logic                 branch_enable_out,
    output logic [CNT_WIDTH-1:0] retired_out,
    output logic                 bypass_valid_out,
    output lc3b_reg              bypass_reg_out,
    output lc3b_word             bypass_data_out
);

    // Only the destination field of the IR and the byte-lane bit of the
    // address matter here, so only those are latched.
    logic             valid_q;
    lc3b_control_word control_q;
    lc3b_reg          ir_dest_q;
    lc3b_word         alu_q;
    lc3b_word         mem_rdata_q;
    logic             addr_lsb_q;
    lc3b_word         pc_q;

    lc3b_nzp              cc_q, cc_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    lc3b_word wb_data;
    lc3b_nzp  wb_nzp;

    logic unused_inputs;
    assign unused_inputs = ^{ir_in[15:12], ir_in[8:0], mem_addr_in[15:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            control_q   <= '0;
            ir_dest_q   <= '0;
            alu_q       <= '0;
            mem_rdata_q <= '0;
            addr_lsb_q  <= 1'b0;
            pc_q        <= '0;
            cc_q        <= CC_RESET;
            retired_q   <= '0;
        end else begin
            valid_q     <= valid_in;
            control_q   <= control_in;
            ir_dest_q   <= ir_in[11:9];
            alu_q       <= alu_in;
            mem_rdata_q <= mem_rdata_in;
            addr_lsb_q  <= mem_addr_in[0];
            pc_q        <= pc_in;
            cc_q        <= cc_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        case (control_q.wb_sel)
            WB_ALU:      wb_data = alu_q;
            WB_MEM_WORD: wb_data = mem_rdata_q;
            WB_MEM_BYTE: wb_data = addr_lsb_q ? {8'h00, mem_rdata_q[15:8]}
                                              : {8'h00, mem_rdata_q[7:0]};
            WB_PC:       wb_data = pc_q;
            default:     wb_data = alu_q;
        endcase
    end

    stage_wb_nzp_gen u_nzp_gen (
        .word_i (wb_data),
        .nzp_o  (wb_nzp)
    );

    always_comb begin
        cc_d      = cc_q;
        retired_d = retired_q;
        if (valid_q && control_q.load_cc) begin
            cc_d = wb_nzp;
        end
        // Natural wrap at 2^CNT_WIDTH.
        if (valid_q) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end
    end

    assign regfile_dest_out  = control_q.dest_sel ? LINK_REG : ir_dest_q;
    assign regfile_data_out  = wb_data;
    assign regfile_load_out  = valid_q & control_q.regfile_load;
    assign cc_out            = cc_q;
    assign branch_enable_out = |(ir_in[11:9] & cc_q);
    assign retired_out       = retired_q;

`ifdef WB_BYPASS_EN
    assign bypass_valid_out = regfile_load_out;
    assign bypass_reg_out   = regfile_dest_out;
    assign bypass_data_out  = regfile_data_out;
`else
    assign bypass_valid_out = 1'b0;
    assign bypass_reg_out   = '0;
    assign bypass_data_out  = '0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;
    import stage_wb_pkg::*;

    localparam int         CW       = 8;
    localparam logic [2:0] CC_RST   = 3'b010;

    typedef struct packed {
        logic             valid;
        logic [15:0]      ir;
        lc3b_control_word ctl;
        logic [15:0]      alu;
        logic [15:0]      mem;
        logic [15:0]      addr;
        logic [15:0]      pc;
    } in_t;

    typedef struct {
        in_t         in;
        logic [2:0]  exp_dest;
        logic [15:0] exp_data;
        logic        exp_load;
        logic [2:0]  exp_cc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;

    logic [2:0]    dest_o;
    logic [15:0]   data_o;
    logic          load_o;
    logic [2:0]    cc_o;
    logic          br_o;
    logic [CW-1:0] ret_o;
    logic          bpv_o;
    logic [2:0]    bpr_o;
    logic [15:0]   bpd_o;

    int tests = 0;
    int fails = 0;

    // Reference model state
    in_t        m_stg = '0;
    logic [2:0] m_cc  = CC_RST;
    int         m_ret = 0;

    always #5 clk = ~clk;

    stage_wb #(.CNT_WIDTH(CW), .CC_RESET(CC_RST)) dut (
        .clk               (clk),
        .reset             (rst),
        .valid_in          (cur.valid),
        .ir_in             (cur.ir),
        .control_in        (cur.ctl),
        .alu_in            (cur.alu),
        .mem_rdata_in      (cur.mem),
        .mem_addr_in       (cur.addr),
        .pc_in             (cur.pc),
        .regfile_dest_out  (dest_o),
        .regfile_data_out  (data_o),
        .regfile_load_out  (load_o),
        .cc_out            (cc_o),
        .branch_enable_out (br_o),
        .retired_out       (ret_o),
        .bypass_valid_out  (bpv_o),
        .bypass_reg_out    (bpr_o),
        .bypass_data_out   (bpd_o)
    );

    function automatic logic [15:0] m_data(in_t s);
        int sel;
        sel = int'(s.ctl.wb_sel);
        if (sel == 1) return s.mem;
        if (sel == 2) return (s.mem >> (s.addr[0] ? 8 : 0)) & 16'h00FF;
        if (sel == 3) return s.pc;
        return s.alu;
    endfunction

    function automatic logic [2:0] m_nzp(logic [15:0] w);
        if ($signed(w) < 0) return 3'b100;
        if (w == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock edge: advance the model, leave 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_stg = '0;
            m_cc  = CC_RST;
            m_ret = 0;
        end else begin
            if (m_stg.valid && m_stg.ctl.load_cc) m_cc = m_nzp(m_data(m_stg));
            if (m_stg.valid) m_ret = (m_ret + 1) % (1 << CW);
            m_stg = cur;
        end
        #1;
    endtask

    task automatic check_all();
        logic [2:0] exp_dest;
        exp_dest = m_stg.ctl.dest_sel ? 3'd7 : m_stg.ir[11:9];
        check("load", load_o, m_stg.valid & m_stg.ctl.regfile_load);
        check("dest", dest_o, exp_dest);
        check("data", data_o, m_data(m_stg));
        check("cc", cc_o, m_cc);
        check("retired", ret_o, m_ret);
        check("branch_en", br_o, |(cur.ir[11:9] & m_cc));
`ifdef WB_BYPASS_EN
        check("bp_valid", bpv_o, m_stg.valid & m_stg.ctl.regfile_load);
        check("bp_reg", bpr_o, exp_dest);
        check("bp_data", bpd_o, m_data(m_stg));
`else
        check("bp_zero", {bpv_o, bpr_o, bpd_o}, 20'h0);
`endif
    endtask

    function automatic in_t mk(logic v, logic [15:0] ir, logic ld, logic lcc, logic ds,
                               logic [2:0] sel, logic [15:0] alu, logic [15:0] mem,
                               logic [15:0] addr, logic [15:0] pc);
        in_t r;
        r.valid = v; r.ir = ir;
        r.ctl.regfile_load = ld; r.ctl.load_cc = lcc; r.ctl.dest_sel = ds;
        r.ctl.wb_sel = lc3b_wb_sel'(sel);
        r.alu = alu; r.mem = mem; r.addr = addr; r.pc = pc;
        return r;
    endfunction

    vec_t vecs[7];
    int   n_valid;

    initial begin
        vecs[0] = '{mk(1, 16'h1240, 1, 1, 0, 3'd0, 16'h8000, 16'h0, 16'h0, 16'h0), 3'd1, 16'h8000, 1'b1, 3'b100};
        vecs[1] = '{mk(1, 16'h2A00, 1, 1, 0, 3'd2, 16'h0, 16'hAB34, 16'h0011, 16'h0), 3'd5, 16'h00AB, 1'b1, 3'b001};
        vecs[2] = '{mk(1, 16'h2A00, 1, 1, 0, 3'd2, 16'h0, 16'hAB34, 16'h0010, 16'h0), 3'd5, 16'h0034, 1'b1, 3'b001};
        vecs[3] = '{mk(1, 16'h4800, 1, 0, 1, 3'd3, 16'h0, 16'h0, 16'h0, 16'h3002), 3'd7, 16'h3002, 1'b1, 3'b001};
        vecs[4] = '{mk(0, 16'h0000, 1, 1, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0), 3'd0, 16'h0000, 1'b0, 3'b001};
        vecs[5] = '{mk(1, 16'h6600, 1, 1, 0, 3'd1, 16'h5555, 16'h0000, 16'h0, 16'h0), 3'd3, 16'h0000, 1'b1, 3'b010};
        vecs[6] = '{mk(1, 16'h0E00, 1, 1, 0, 3'd5, 16'h1234, 16'hFFFF, 16'h0, 16'h9999), 3'd7, 16'h1234, 1'b1, 3'b001};

        // Reset state
        rst = 1'b1; cur = '0;
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_load", load_o, 1'b0);
        check("rst_cc", cc_o, CC_RST);
        check("rst_ret", ret_o, 0);
        check("rst_data", data_o, 16'h0);
        check("rst_dest", dest_o, 3'd0);
        check_all();

        // Directed table; each vector is followed by a bubble so its CC commit is visible.
        n_valid = 0;
        foreach (vecs[i]) begin
            cur = vecs[i].in;
            tick();
            cur = '0; #1;
            check($sformatf("v%0d_dest", i), dest_o, vecs[i].exp_dest);
            check($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
            check($sformatf("v%0d_load", i), load_o, vecs[i].exp_load);
            check_all();
            tick(); #1;
            check($sformatf("v%0d_cc", i), cc_o, vecs[i].exp_cc);
            check_all();
            if (vecs[i].in.valid) n_valid++;
        end
        check("table_retired", ret_o, n_valid);

        // Back-to-back writes to the same register commit in order.
        cur = mk(1, 16'h0400, 1, 1, 0, 3'd0, 16'h0001, 0, 0, 0);
        tick();
        cur = mk(1, 16'h0400, 1, 1, 0, 3'd0, 16'hFFFE, 0, 0, 0); #1;
        check("b2b_first", data_o, 16'h0001);
        check_all();
        tick();
        cur = '0; #1;
        check("b2b_cc_first", cc_o, 3'b001);
        check("b2b_second", data_o, 16'hFFFE);
        check_all();
        tick(); #1;
        check("b2b_cc_last", cc_o, 3'b100);
        check_all();

        // Reset mid-write drops the in-flight write.
        cur = mk(1, 16'h0200, 1, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        tick();
        rst = 1'b1;
        cur = mk(1, 16'h0600, 1, 1, 0, 3'd0, 16'h0007, 0, 0, 0);
        tick();
        rst = 1'b0; cur = '0; #1;
        check("midrst_load", load_o, 1'b0);
        check("midrst_cc", cc_o, CC_RST);
        check("midrst_ret", ret_o, 0);
        check_all();

        // Retire counter wrap: with valid every cycle the count trails by one edge.
        cur = mk(1, 16'h0000, 0, 0, 0, 3'd0, 16'h0, 0, 0, 0);
        for (int k = 0; k < (1 << CW); k++) begin
            tick();
            #1; check_all();
        end
        check("ret_all_ones", ret_o, (1 << CW) - 1);
        tick();
        cur = '0; #1;
        check("ret_wrap", ret_o, 0);
        check_all();
        tick(); #1;
        check("ret_bubble_hold", ret_o, 1);
        check_all();

        // Randomised traffic against the model, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            tick();
            rst = ($urandom_range(0, 49) == 0);
            cur.valid = ($urandom_range(0, 3) != 0);
            cur.ir    = 16'($urandom);
            cur.ctl   = lc3b_control_word'(6'($urandom));
            cur.alu   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cur.mem   = 16'($urandom);
            cur.addr  = 16'($urandom);
            cur.pc    = 16'($urandom);
            #1; check_all();
        end
        rst = 1'b0;
        tick(); #1; check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
